// File: rtl/io_bus_pkg.sv
// Shared definitions for the CPU I/O bus controller: FSM encoding, idle data byte, counter widths.
// The INTA state exists only when IO_BUS_INTACK_EN is defined.
package io_bus_pkg;

    localparam int WAIT_CNT_W = 3;
    localparam int TO_CNT_W   = 8;

    localparam logic [7:0] DATA_IDLE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACCESS = 3'd2,
        RDWAIT = 3'd3,
`ifdef IO_BUS_INTACK_EN
        HOLD   = 3'd4,
        INTA   = 3'd5
`else
        HOLD   = 3'd4
`endif
    } state_e;

endpackage

// File: rtl/io_bus_ctl.sv
// CPU-side I/O bus controller: wait-state insertion, one-shot peripheral strobes, read timeout.
// Define IO_BUS_INTACK_EN to add interrupt-acknowledge handling (INTA state, pending flag, inta pulse).
module io_bus_ctl
    import io_bus_pkg::*;
#(
    parameter int         WAIT_STATES = 1,
    parameter int         RD_TIMEOUT  = 255,
    parameter logic [7:0] INT_VECTOR  = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    input  logic [7:0] addr,
    input  logic [7:0] DO,
    output logic [7:0] DI,
    output logic       wait_n,
    output logic [7:0] io_addr,
    output logic [7:0] io_wdata,
    output logic       io_wr,
    output logic       io_rd,
    input  logic [7:0] io_rdata,
    input  logic       io_rvalid,
    input  logic       int_req,
    output logic       int_n,
    output logic       inta,
    output logic       rd_err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_STATES - 1);
    localparam logic [TO_CNT_W-1:0]   TO_LAST   = TO_CNT_W'(RD_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [TO_CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic                  is_wr_q, is_wr_d;
    logic [7:0]            io_addr_q, io_addr_d;
    logic [7:0]            io_wdata_q, io_wdata_d;
    logic [7:0]            rdata_q, rdata_d;
    logic                  rd_err_q, rd_err_d;
    logic                  cpu_io;
    logic                  in_inta;

    assign cpu_io = !iorq_n && m1_n && (!wr_n || !rd_n);

`ifdef IO_BUS_INTACK_EN
    logic int_ack;
    logic pend_q, pend_d;
    logic inta_q, inta_d;

    assign int_ack = !iorq_n && !m1_n;
    assign in_inta = (state_q == INTA);

    // A request arriving alongside the acknowledge pulse must survive the clear.
    always_comb begin
        pend_d = int_req | (pend_q & ~inta_q);
        inta_d = (state_q == IDLE) && int_ack;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
            inta_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            inta_q <= inta_d;
        end
    end

    assign int_n = ~pend_q;
    assign inta  = inta_q;
`else
    logic int_n_q;

    assign in_inta = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) int_n_q <= 1'b1;
        else       int_n_q <= ~int_req;
    end

    assign int_n = int_n_q;
    assign inta  = 1'b0;
`endif

    // Next-state process.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
        is_wr_d    = is_wr_q;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
        rdata_d    = rdata_q;
        rd_err_d   = rd_err_q;
        unique case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                to_cnt_d   = '0;
                if (cpu_io) begin
                    io_addr_d = addr;
                    is_wr_d   = !wr_n;
                    if (!wr_n) io_wdata_d = DO;
                    state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
`ifdef IO_BUS_INTACK_EN
                else if (int_ack) begin
                    state_d = INTA;
                end
`endif
            end
            WAIT: begin
                if (iorq_n)                       state_d = IDLE;
                else if (wait_cnt_q == WAIT_LAST) state_d = ACCESS;
                else                              wait_cnt_d = wait_cnt_q + 1'b1;
            end
            ACCESS: begin
                if (is_wr_q) begin
                    state_d = HOLD;
                end else if (io_rvalid) begin
                    rdata_d = io_rdata;
                    state_d = HOLD;
                end else begin
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                if (io_rvalid) begin
                    rdata_d = io_rdata;
                    state_d = HOLD;
                end else if (to_cnt_q == TO_LAST) begin
                    rdata_d  = DATA_IDLE;
                    rd_err_d = 1'b1;
                    state_d  = HOLD;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (iorq_n) state_d = IDLE;
            end
`ifdef IO_BUS_INTACK_EN
            INTA: begin
                if (iorq_n) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            to_cnt_q   <= '0;
            is_wr_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            rdata_q    <= DATA_IDLE;
            rd_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            is_wr_q    <= is_wr_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
            rdata_q    <= rdata_d;
            rd_err_q   <= rd_err_d;
        end
    end

    // Outputs decode from state only, so reset clears strobes and wait_n asynchronously.
    always_comb begin
        wait_n = 1'b1;
        io_wr  = 1'b0;
        io_rd  = 1'b0;
        DI     = DATA_IDLE;
        unique case (state_q)
            WAIT:   wait_n = 1'b0;
            ACCESS: begin
                wait_n = 1'b0;
                io_wr  = is_wr_q;
                io_rd  = !is_wr_q;
            end
            RDWAIT: wait_n = 1'b0;
            HOLD:   if (!is_wr_q) DI = rdata_q;
            default: ;
        endcase
        if (in_inta) DI = INT_VECTOR;
    end

    assign io_addr  = io_addr_q;
    assign io_wdata = io_wdata_q;
    assign rd_err   = rd_err_q;

endmodule

// File: doc/io_bus_ctl.md
IO_BUS_CTL -- requirements
Module: io_bus_ctl

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1, meaning the number of wait cycles (0..7) inserted before every I/O strobe.
REQ-002 The block SHALL have parameter RD_TIMEOUT, default 255, meaning the maximum number of cycles (1..255) to wait for io_rvalid.
REQ-003 The block SHALL have parameter INT_VECTOR, default 8'hFF, meaning the byte returned on interrupt acknowledge.
REQ-004 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state on rising edge
  reset  in  1  asynchronous, active-high reset
  iorq_n  in  1  CPU I/O request, active low
  rd_n  in  1  CPU read strobe, active low
  wr_n  in  1  CPU write strobe, active low
  m1_n  in  1  CPU M1, active low (with iorq_n low = interrupt acknowledge)
  addr  in  8  CPU port address
  DO  in  8  CPU write data
  DI  out  8  read data to CPU
  wait_n  out  1  wait request to CPU, active low
  io_addr  out  8  captured port address
  io_wdata  out  8  captured write data
  io_wr  out  1  one-cycle write strobe to peripherals
  io_rd  out  1  one-cycle read strobe to peripherals
  io_rdata  in  8  peripheral read data
  io_rvalid  in  1  peripheral read data valid
  int_req  in  1  one-cycle interrupt request pulse from peripherals
  int_n  out  1  interrupt to CPU, active low
  inta  out  1  one-cycle interrupt-acknowledge pulse
  rd_err  out  1  sticky read-timeout flag

Function
REQ-005 The FSM SHALL have states IDLE, WAIT, ACCESS, RDWAIT, HOLD, INTA.
REQ-006 In IDLE, on a cycle with iorq_n=0, m1_n=1 and either wr_n=0 or rd_n=0, the block SHALL capture addr into io_addr, capture DO into io_wdata (writes only), record the direction, and go to WAIT, or straight to ACCESS when WAIT_STATES=0.
REQ-007 WAIT SHALL last exactly WAIT_STATES cycles, then go to ACCESS.
REQ-008 In ACCESS, a write SHALL assert io_wr for exactly one cycle and go to HOLD.
REQ-009 In ACCESS, a read SHALL assert io_rd for exactly one cycle and go to RDWAIT.
REQ-010 In RDWAIT, the first cycle with io_rvalid=1 SHALL latch io_rdata and go to HOLD; io_rvalid in the io_rd cycle itself SHALL be accepted.
REQ-011 If RDWAIT lasts RD_TIMEOUT cycles without io_rvalid, the block SHALL latch 8'hFF, set rd_err, and go to HOLD.
REQ-012 wait_n SHALL be 0 in WAIT, ACCESS and RDWAIT, and 1 in all other states.
REQ-013 HOLD SHALL return to IDLE on the first cycle with iorq_n=1; a new cycle SHALL NOT start in the same cycle.
REQ-014 If iorq_n rises in WAIT, the block SHALL return to IDLE with no strobe (abort).
REQ-015 DI SHALL equal the latched read data while in HOLD for a read, INT_VECTOR while in INTA, and 8'hFF otherwise.
REQ-016 io_wr and io_rd SHALL never both be 1; each SHALL pulse at most once per CPU cycle.
REQ-017 The wait counter SHALL be 3 bits and the timeout counter 8 bits; both SHALL clear on every entry to IDLE.
REQ-018 rd_err SHALL be cleared only by reset.

Reset
REQ-019 While reset=1, the block SHALL asynchronously force: state IDLE, wait_n=1, io_wr=0, io_rd=0, inta=0, int_n=1, rd_err=0, io_addr=0, io_wdata=0, read latch=8'hFF, interrupt pending=0, counters=0.
REQ-020 A reset during any state SHALL abandon the cycle with no strobe on release.

Configuration
REQ-021 With IO_BUS_INTACK_EN defined, int_req SHALL set a pending flag, and int_n SHALL be the inverse of that flag.
REQ-022 With IO_BUS_INTACK_EN defined, IDLE with iorq_n=0 and m1_n=0 SHALL enter INTA, pulse inta for one cycle, clear pending, and return to IDLE when iorq_n=1.
REQ-023 With IO_BUS_INTACK_EN defined, an int_req in the same cycle as the inta pulse SHALL leave pending set.
REQ-024 Without IO_BUS_INTACK_EN, int_n SHALL be the registered inverse of int_req, acknowledge cycles SHALL be ignored (DI=8'hFF), inta SHALL be tied to 0, and the INTA state SHALL be absent.

Structure
REQ-025 A shared package io_bus_pkg SHALL hold the state encoding, the 8'hFF idle/timeout data constant and the counter widths.
REQ-026 The block SHALL be a single module with no sub-modules; the cycle FSM is small enough to stay inline.

Verification
REQ-027 Write test, WAIT_STATES=2, addr=8'h81, DO=8'h41: wait_n low for 3 cycles; io_wr pulses once with io_addr=8'h81, io_wdata=8'h41.
REQ-028 Read test, io_rvalid 4 cycles after io_rd with io_rdata=8'h5A: DI=8'h5A in HOLD; exactly one io_rd pulse.
REQ-029 Read test with io_rvalid never asserted, RD_TIMEOUT=255: after 255 cycles DI=8'hFF, rd_err=1, wait_n returns high.
REQ-030 Interrupt test with IO_BUS_INTACK_EN, INT_VECTOR=8'hCF: int_req pulse gives int_n=0; an M1+IORQ cycle gives DI=8'hCF, one inta pulse, int_n=1; int_req coincident with inta keeps int_n=0.
REQ-031 Abort test: iorq_n rises during WAIT gives no io_wr; reset asserted in RDWAIT gives wait_n=1 immediately and no strobes after release.
